// File: rtl/gardner_ted_core_if.sv
// Sample-in / error-out bundle for the Gardner timing-error detector.
// Ports: clr_i, i_in, q_in, in_valid_i, sym_valid_i (towards the detector);
//        e_out_o, e_valid_o, sat_o (back from the detector).
interface gardner_ted_core_if #(
   parameter int WIQ  = 16,
   parameter int WERR = 18
);
   logic                   clr_i;
   logic signed [WIQ-1:0]  i_in;
   logic signed [WIQ-1:0]  q_in;
   logic                   in_valid_i;
   logic                   sym_valid_i;
   logic signed [WERR-1:0] e_out_o;
   logic                   e_valid_o;
   logic                   sat_o;

   // master: interpolator / stimulus side, slave: the detector
   modport master (
      output clr_i, i_in, q_in, in_valid_i, sym_valid_i,
      input  e_out_o, e_valid_o, sat_o
   );
   modport slave (
      input  clr_i, i_in, q_in, in_valid_i, sym_valid_i,
      output e_out_o, e_valid_o, sat_o
   );
endinterface

// File: rtl/gardner_ted_core.sv
// Gardner timing-error detector: e = Ih*(Ic-Ip) + Qh*(Qc-Qp), scaled by >>>SHIFT and saturated to WERR bits.
// Latency: strobe captured on edge t, e_valid_o pulses in the cycle after edge t+2 (3 register stages).
// Backpressure: none; fully pipelined, one result per accepted strobe. Ports: clk, reset, ted (slave modport).
module gardner_ted_core #(
   parameter int OSF   = 20,
   parameter int WIQ   = 16,
   parameter int WERR  = 18,
   parameter int SHIFT = WIQ + $clog2(OSF) - WERR,
   parameter int MODE  = 0
)(
   input  logic              clk,
   input  logic              reset,
   gardner_ted_core_if.slave ted
);
   localparam int HALF = OSF / 2;
   localparam int FW   = $clog2(OSF + 1);
   localparam int PW   = 2 * WIQ + 1;
   localparam int SW   = 2 * WIQ + 2;
   localparam logic signed [SW-1:0] EMAX = {{(SW-WERR+1){1'b0}}, {(WERR-1){1'b1}}};
   localparam logic signed [SW-1:0] EMIN = {{(SW-WERR+1){1'b1}}, {(WERR-1){1'b0}}};

   // Delay line: index 0 holds sample n-1, index OSF-1 holds sample n-OSF.
   logic signed [WIQ-1:0] dl_i [OSF];
   logic signed [WIQ-1:0] dl_q [OSF];
   logic [FW-1:0]         fill_cnt;

   logic                  accept;
   logic                  strobe;

   logic                  s1_vld;
   logic signed [WIQ-1:0] s1_ic, s1_ih, s1_ip, s1_qc, s1_qh, s1_qp;
   logic                  s2_vld;
   logic signed [PW-1:0]  s2_prod_i, s2_prod_q;

   logic signed [WIQ:0]    d_i, d_q;
   logic signed [PW-1:0]   prod_i_nxt, prod_q_nxt;
   logic signed [SW-1:0]   sum, sum_sh;
   logic signed [WERR-1:0] e_nxt;
   logic                   clip;

   // clr_i wins over in_valid_i: the sample presented with it is discarded.
   assign accept = ted.in_valid_i & ~ted.clr_i;
   // Warm-up gate compares the count before this sample's own increment.
   assign strobe = accept & ted.sym_valid_i & (fill_cnt == FW'(OSF));

   // Data-only storage; anything stale is masked by the warm-up gate.
   always_ff @(posedge clk) begin
      if (accept) begin
         dl_i[0] <= ted.i_in;
         dl_q[0] <= ted.q_in;
         for (int k = 1; k < OSF; k++) begin
            dl_i[k] <= dl_i[k-1];
            dl_q[k] <= dl_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_cnt <= '0;
      end else if (ted.clr_i) begin
         fill_cnt <= '0;
      end else if (accept && fill_cnt != FW'(OSF)) begin
         fill_cnt <= fill_cnt + FW'(1);
      end
   end

   // Stage 1: tap capture. Ic/Qc come straight from the port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s1_ic  <= '0;
         s1_ih  <= '0;
         s1_ip  <= '0;
         s1_qc  <= '0;
         s1_qh  <= '0;
         s1_qp  <= '0;
      end else begin
         s1_vld <= strobe;
         if (strobe) begin
            s1_ic <= ted.i_in;
            s1_ih <= dl_i[HALF-1];
            s1_ip <= dl_i[OSF-1];
            s1_qc <= ted.q_in;
            s1_qh <= dl_q[HALF-1];
            s1_qp <= dl_q[OSF-1];
         end
      end
   end

   always_comb begin
      d_i        = (WIQ+1)'(s1_ic) - (WIQ+1)'(s1_ip);
      d_q        = (WIQ+1)'(s1_qc) - (WIQ+1)'(s1_qp);
      prod_i_nxt = PW'(s1_ih) * PW'(d_i);
      prod_q_nxt = (MODE == 1) ? '0 : PW'(s1_qh) * PW'(d_q);
   end

   // Stage 2: products.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_vld    <= 1'b0;
         s2_prod_i <= '0;
         s2_prod_q <= '0;
      end else begin
         s2_vld <= s1_vld & ~ted.clr_i;
         if (s1_vld) begin
            s2_prod_i <= prod_i_nxt;
            s2_prod_q <= prod_q_nxt;
         end
      end
   end

   // Sum is one bit wider than the products, so it cannot wrap; the shift floors.
   always_comb begin
      sum    = SW'(s2_prod_i) + SW'(s2_prod_q);
      sum_sh = sum >>> SHIFT;
      clip   = 1'b0;
      e_nxt  = sum_sh[WERR-1:0];
      if (sum_sh > EMAX) begin
         e_nxt = EMAX[WERR-1:0];
         clip  = 1'b1;
      end else if (sum_sh < EMIN) begin
         e_nxt = EMIN[WERR-1:0];
         clip  = 1'b1;
      end
   end

   // Stage 3: output. e_out_o holds between pulses; sat_o only qualifies a pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ted.e_out_o   <= '0;
         ted.e_valid_o <= 1'b0;
         ted.sat_o     <= 1'b0;
      end else begin
         ted.e_valid_o <= s2_vld & ~ted.clr_i;
         ted.sat_o     <= s2_vld & ~ted.clr_i & clip;
         if (s2_vld && !ted.clr_i) begin
            ted.e_out_o <= e_nxt;
         end
      end
   end
endmodule

// File: tb/tb_gardner_ted_core.sv
// Bench for gardner_ted_core: two instances (I+Q and I-only) share one stimulus stream.
// Expected errors come from a behavioural model of the tap history, queued with their due edge.
// Ports covered: clk, reset and every field of both interface instances.
module tb_gardner_ted_core;
   localparam int OSF  = 20;
   localparam int WIQ  = 16;
   localparam int WERR = 18;
   localparam int SH   = 3;
   localparam longint EMAX = 131071;
   localparam longint EMIN = -131072;

   typedef struct {
      int e;
      int sat;
      int due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gardner_ted_core_if #(.WIQ(WIQ), .WERR(WERR)) bus0 ();
   gardner_ted_core_if #(.WIQ(WIQ), .WERR(WERR)) bus1 ();

   gardner_ted_core #(.OSF(OSF), .WIQ(WIQ), .WERR(WERR), .MODE(0)) dut0 (
      .clk(clk), .reset(reset), .ted(bus0));
   gardner_ted_core #(.OSF(OSF), .WIQ(WIQ), .WERR(WERR), .MODE(1)) dut1 (
      .clk(clk), .reset(reset), .ted(bus1));

   exp_t q0[$];
   exp_t q1[$];
   int   hist_i[$];
   int   hist_q[$];
   int   fill;
   int   errors = 0;
   int   checks = 0;
   int   edge_cnt = 0;
   int   gap = 0;
   int   pulses[2];
   int   last_e[2];
   int   last_sat[2];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic void model(input longint s, output int e, output int sat);
      longint sh;
      sh  = s >>> SH;
      sat = 0;
      if (sh > EMAX) begin sh = EMAX; sat = 1; end
      else if (sh < EMIN) begin sh = EMIN; sat = 1; end
      e = int'(sh);
   endfunction

   task automatic flush_model();
      fill = 0;
      hist_i.delete();
      hist_q.delete();
   endtask

   task automatic drop_from(input int lim);
      while (q0.size() > 0 && q0[$].due >= lim) void'(q0.pop_back());
      while (q1.size() > 0 && q1[$].due >= lim) void'(q1.pop_back());
   endtask

   task automatic drive(input int i, input int q, input bit iv, input bit sv, input bit clr);
      bus0.i_in = WIQ'(i);  bus1.i_in = WIQ'(i);
      bus0.q_in = WIQ'(q);  bus1.q_in = WIQ'(q);
      bus0.in_valid_i = iv;  bus1.in_valid_i = iv;
      bus0.sym_valid_i = sv; bus1.sym_valid_i = sv;
      bus0.clr_i = clr;      bus1.clr_i = clr;
   endtask

   // One clock of stimulus; the model mirrors acceptance and warm-up behaviour.
   task automatic step(input int i, input int q, input bit iv, input bit sv, input bit clr);
      exp_t x;
      longint si, sq;
      int n;
      drive(i, q, iv, sv, clr);
      if (clr) begin
         flush_model();
         drop_from(edge_cnt + 1);
      end else if (iv) begin
         if (sv && fill == OSF) begin
            n  = hist_i.size();
            si = longint'(hist_i[n-OSF/2]) * longint'(i - hist_i[n-OSF]);
            sq = longint'(hist_q[n-OSF/2]) * longint'(q - hist_q[n-OSF]);
            x.due = edge_cnt + 3;
            model(si + sq, x.e, x.sat);
            q0.push_back(x);
            model(si, x.e, x.sat);
            q1.push_back(x);
         end
         hist_i.push_back(i);
         hist_q.push_back(q);
         if (hist_i.size() > OSF) begin
            void'(hist_i.pop_front());
            void'(hist_q.pop_front());
         end
         if (fill < OSF) fill++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int i, input int q, input bit sv);
      step(i, q, 1'b1, sv, 1'b0);
      repeat (gap) step(12345, -4321, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 20) begin
         step(0, 0, 1'b0, 1'b0, 1'b0);
         n++;
      end
      repeat (3) step(0, 0, 1'b0, 1'b0, 1'b0);
      chk("drain_pending", q0.size() + q1.size(), 0);
   endtask

   task automatic mon(input int p, input logic ev, input int eo, input int so);
      exp_t x;
      bit have;
      have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) x = (p == 0) ? q0[0] : q1[0];
      if (ev === 1'b1) begin
         pulses[p]++;
         last_e[p]   = eo;
         last_sat[p] = so;
         chk($sformatf("unexpected_pulse_p%0d", p), int'(have), 1);
         if (have) begin
            if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            chk($sformatf("e_out_p%0d", p), eo, x.e);
            chk($sformatf("sat_p%0d", p), so, x.sat);
            chk($sformatf("latency_edge_p%0d", p), edge_cnt, x.due);
         end
      end else begin
         chk($sformatf("sat_idle_p%0d", p), so, 0);
         if (have) chk($sformatf("pulse_missing_p%0d", p), int'(x.due > edge_cnt), 1);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         mon(0, bus0.e_valid_o, int'(bus0.e_out_o), int'(bus0.sat_o));
         mon(1, bus1.e_valid_o, int'(bus1.e_out_o), int'(bus1.sat_o));
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int p0, p1, le;
      pulses = '{0, 0};
      last_e = '{0, 0};
      last_sat = '{0, 0};
      flush_model();
      reset = 1'b1;
      drive(0, 0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("reset_e_out", int'(bus0.e_out_o), 0);
      chk("reset_e_valid", int'(bus0.e_valid_o), 0);
      chk("reset_sat", int'(bus0.sat_o), 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Warm-up: strobe at k=19 dropped, k=20 honoured
      p0 = pulses[0];
      for (int k = 0; k <= 20; k++) sample(10 * k, 0, k == 19 || k == 20);
      drain();
      chk("warmup_pulses", pulses[0] - p0, 1);
      chk("warmup_e", last_e[0], 2500);
      chk("warmup_sat", last_sat[0], 0);
      chk("warmup_e_ionly", last_e[1], 2500);

      // Negative ramp
      step(0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= 20; k++) sample(-10 * k, 0, k == 20);
      drain();
      chk("neg_ramp_e", last_e[0], 2500);

      // I+Q versus I-only
      step(0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= 20; k++) sample(10 * k, -10 * k, k == 20);
      drain();
      chk("iq_e_mode0", last_e[0], 5000);
      chk("iq_e_mode1", last_e[1], 2500);

      // Floor on negative sum: -3 >>> 3 = -1
      step(0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= 20; k++) sample((k == 10) ? -1 : ((k == 20) ? 3 : 0), 0, k == 20);
      drain();
      chk("floor_e", last_e[0], -1);

      // Positive saturation
      step(0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= 20; k++) sample(100 * k, 0, k == 20);
      drain();
      chk("satpos_e", last_e[0], 131071);
      chk("satpos_flag", last_sat[0], 1);

      // Negative saturation
      step(0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= 20; k++) sample((k == 10) ? -1000 : 100 * k, 0, k == 20);
      drain();
      chk("satneg_e", last_e[0], -131072);
      chk("satneg_flag", last_sat[0], 1);

      // Constant input, gapped in_valid_i (1 of 3)
      step(0, 0, 1'b0, 1'b0, 1'b1);
      gap = 2;
      p0 = pulses[0];
      for (int k = 0; k <= 60; k++) sample(1000, -500, (k % 20) == 0);
      gap = 0;
      drain();
      chk("const_pulses", pulses[0] - p0, 3);
      chk("const_e", last_e[0], 0);

      // Back-to-back strobes
      step(0, 0, 1'b0, 1'b0, 1'b1);
      p0 = pulses[0];
      p1 = pulses[1];
      for (int k = 0; k <= 23; k++) sample(10 * k, int'($urandom_range(0, 2000)) - 1000, k >= 20);
      drain();
      chk("b2b_pulses", pulses[0] - p0, 4);
      chk("b2b_pulses_ionly", pulses[1] - p1, 4);
      chk("b2b_last_ionly", last_e[1], 250 * 13);

      // clr_i right after a strobe kills it; warm-up restarts
      step(0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k <= 19; k++) sample(10 * k, 0, 1'b0);
      le = last_e[0];
      p0 = pulses[0];
      sample(200, 0, 1'b1);
      step(0, 0, 1'b0, 1'b0, 1'b1);
      repeat (4) step(0, 0, 1'b0, 1'b0, 1'b0);
      chk("clr_no_pulse", pulses[0] - p0, 0);
      chk("clr_e_hold", int'(bus0.e_out_o), le);
      for (int k = 0; k <= 20; k++) sample(10 * k, 0, k >= 10);
      drain();
      chk("clr_rewarm_pulses", pulses[0] - p0, 1);
      chk("clr_rewarm_e", last_e[0], 2500);

      // Async reset mid-stream
      step(0, 0, 1'b0, 1'b0, 1'b1);
      p0 = pulses[0];
      for (int k = 0; k <= 20; k++) sample(100 * k, 0, k == 20);
      reset = 1'b1;
      flush_model();
      q0.delete();
      q1.delete();
      #1;
      chk("rst_mid_e_out", int'(bus0.e_out_o), 0);
      chk("rst_mid_e_valid", int'(bus0.e_valid_o), 0);
      chk("rst_mid_e_out_ionly", int'(bus1.e_out_o), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k <= 20; k++) sample(10 * k, 0, k >= 15);
      drain();
      chk("rst_rewarm_pulses", pulses[0] - p0, 1);
      chk("rst_rewarm_e", last_e[0], 2500);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gardner_ted_core.md
# gardner_ted_core

Synthesizable, parametrised Gardner timing-error detector for the MSK receiver timing loop. Accepts a strobed I/Q sample stream at OSF samples/symbol from the interpolator, stores the last OSF samples in a register delay line, and on each symbol strobe computes e = Ih·(Ic−Ip) + Qh·(Qc−Qp) through a 3-stage pipeline with arithmetic scaling and saturation. It adds sample-valid qualification, warm-up gating, I-only mode, synchronous clear and a saturation flag, and feeds the loop filter.

## Interface
- OSF, 20, samples per symbol; even, ≥ 4
- WIQ, 16, signed I/Q input width
- WERR, 18, signed error output width
- SHIFT, WIQ+$clog2(OSF)−WERR (=3), arithmetic right shift applied before saturation; ≥ 0
- MODE, 0, 0 = I+Q error, 1 = I-only error (Q terms forced to 0)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clr_i  in  1  synchronous clear of warm-up count and pipeline valids
- i_in  in  WIQ  signed I sample
- q_in  in  WIQ  signed Q sample
- in_valid_i  in  1  sample qualifier; one sample accepted per high cycle
- sym_valid_i  in  1  current sample is a symbol point; ignored unless in_valid_i high
- e_out_o  out  WERR  signed timing error
- e_valid_o  out  1  one-cycle pulse, e_out_o valid
- sat_o  out  1  e_out_o was saturated; valid with e_valid_o, else 0

## Operation
- Delay line: OSF registered I/Q entries, shifted (or circularly written) on each accepted sample (in_valid_i=1, clr_i=0). Contents need no reset; output is gated by warm-up.
- Taps at a strobe, n = incoming sample: Ic/Qc = sample n (input port, not yet stored), Ih/Qh = n−OSF/2, Ip/Qp = n−OSF.
- Warm-up: fill_cnt counts accepted samples, saturates at OSF. Strobe accepted only if in_valid_i & sym_valid_i & fill_cnt==OSF (before this sample's increment). Strobes before that are silently dropped. First usable strobe is on the (OSF+1)-th accepted sample.
- Arithmetic: dI = Ic−Ip, dQ = Qc−Qp at WIQ+1 bits; products 2·WIQ+1 bits; sum at 2·WIQ+2 bits, no overflow. MODE=1: Qh·dQ term = 0.
- Scaling: sum >>> SHIFT (floor, no rounding). Saturate to [−2^(WERR−1), 2^(WERR−1)−1]; sat_o=1 when clipped.
- clr_i: fill_cnt←0, all pipeline valid bits←0; sample presented with clr_i is not accepted. clr_i has priority over in_valid_i.
- in_valid_i low: delay line, fill_cnt hold; in-flight pipeline stages still advance.

## Timing
- Reset values: e_out_o=0, e_valid_o=0, sat_o=0, fill_cnt=0, pipeline valids=0.
- Pipeline: S1 registers Ic/Ih/Ip/Qc/Qh/Qp + valid; S2 registers dI·Ih, dQ·Qh products; S3 registers sum/shift/saturate into e_out_o, sat_o, e_valid_o.
- Latency: strobe accepted on edge t → e_valid_o high for exactly cycle t+3.
- Fully pipelined: strobes on consecutive accepted samples each give one output, in order, one per cycle; no back-pressure.
- e_out_o holds last value between pulses; sat_o is 0 whenever e_valid_o is 0.
- Reset asserted mid-pipeline: all in-flight results lost, outputs 0 asynchronously. clr_i mid-pipeline: no e_valid_o for strobes accepted before it; e_out_o keeps last value.
- After reset/clr_i: OSF further accepted samples required before a strobe is honoured.

## Test plan
- Warm-up: defaults, in_valid_i=1, i_in=10·k, q_in=0 (k = sample index from 0); sym_valid_i at k=19 → no e_valid_o; at k=20 → e_valid_o 3 cycles later, e_out_o = (100·200)>>>3 = 2500, sat_o=0.
- Sign/floor: i_in=−10·k, same strobe at k=20 → Ih=−100, dI=−200 → e_out_o=20000>>>3=2500; i_in=10·k with q_in=−(10·k), MODE=0 → e=40000>>>3=5000; MODE=1 → 2500.
- Saturation: i_in=100·k, strobe at k=20 → 2 000 000>>>3=250000 → e_out_o=131071, sat_o=1; i_in=−100·k+... negated-half stimulus giving −250000 → −131072, sat_o=1.
- Constant input i_in=1000, q_in=−500, strobes every 20 samples → e_out_o=0 every pulse; gapped in_valid_i (1 of 3 cycles) → identical results, latency still 3 cycles from accepting edge.
- Back-to-back: strobes on 4 consecutive accepted samples after warm-up → 4 consecutive e_valid_o pulses matching a reference model in order.
- clr_i one cycle after a strobe → no e_valid_o for it; next strobe ignored until 20 more accepted samples; async reset mid-stream → outputs 0 immediately, warm-up restarts.
